// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, frame geometry, error-flag indices and CRC32 helpers
// shared by the H2C frame checker and its CRC engine.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    FCS     = 3'd3,
    DROP    = 3'd4
  } state_e;

  localparam logic [15:0] HDR_LEN  = 16'd14;
  localparam logic [2:0]  FCS_LEN  = 3'd4;
  localparam logic [1:0]  FCS_LAST = 2'(FCS_LEN - 3'd1);

  localparam int unsigned ERR_DST = 32'd0;
  localparam int unsigned ERR_LEN = 32'd1;
  localparam int unsigned ERR_PAT = 32'd2;
  localparam int unsigned ERR_FCS = 32'd3;

  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // LSB-first (reflected) update of the running CRC with one byte
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 5'd1) ^ reflect32(CRC_POLY)) : (r >> 5'd1);
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Byte idx (0 = most significant) of a 48-bit MAC address
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    logic [5:0]  amt;
    amt = {3'(3'd5 - idx), 3'b000};
    sh  = mac >> amt;
    return sh[7:0];
  endfunction

endpackage

// File: rtl/traffic_crc32.sv
// traffic_crc32: byte-serial IEEE 802.3 CRC32 accumulator; crc holds the running
// (pre-inversion) value, srst restarts from the init value and may fold in the same byte.
module traffic_crc32
  import traffic_pkg::*;
(
  input  logic        user_clk,
  input  logic        user_resetn,
  input  logic        srst,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_r;
  logic [31:0] base_s;

  assign base_s = srst ? CRC_INIT : crc_r;

  // CRC accumulator register
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      crc_r <= CRC_INIT;
    end else if (en) begin
      crc_r <= crc32_byte(base_s, data);
    end else if (srst) begin
      crc_r <= CRC_INIT;
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/traffic_chk.sv
// traffic_chk: byte-wide H2C frame checker (header, length, payload pattern, FCS) with
// saturating counters and sticky flags. Define TRAFFIC_CHK_CRC_EN to check SRC MAC and a real CRC32 FCS.
module traffic_chk
  import traffic_pkg::*;
#(
  parameter logic [15:0] MAX_ETH_FRAME = 16'd1500,
  parameter logic [47:0] DST_MAC       = 48'h8000_0000_0000,
  parameter logic [47:0] SRC_MAC       = 48'h8000_0000_0001
) (
  input  logic        user_clk,
  input  logic        user_resetn,
  input  logic [31:0] control_reg,
  input  logic        h2c_valid,
  input  logic        h2c_ben,
  input  logic [7:0]  h2c_data,
  input  logic        h2c_last,
  output logic        h2c_ready,
  output logic [31:0] good_frames,
  output logic [31:0] bad_frames,
  output logic [31:0] rx_bytes,
  output logic [3:0]  err_flags,
  output logic        busy
);

  state_e      state_r, state_nx_s;
  logic [15:0] pos_r, pos_nx_s;
  logic [15:0] len_r, len_nx_s;
  logic [3:0]  fe_r;
  logic        en_r, busy_r;
  logic [31:0] good_r, bad_r, rx_r;
  logic [3:0]  flags_r;

  logic        clr_s, accept_s, in_hdr_s, frame_end_s;
  logic        dst_bad_s, src_bad_s;
  logic [15:0] cur_pos_s, len_full_s;
  logic [16:0] pay_end_s;
  logic [7:0]  pay_exp_s, fcs_exp_s;
  logic [1:0]  fcs_idx_s;
  logic [2:0]  src_idx_s;
  logic [3:0]  err_now_s, frame_err_s;
  logic        crc_srst_s, crc_en_s;
  logic        unused_ctrl_s;

  assign clr_s         = control_reg[0];
  assign unused_ctrl_s = ^control_reg[31:2];

  assign h2c_ready = en_r || busy_r;
  assign accept_s  = h2c_valid && h2c_ready && h2c_ben;

  // Header byte position: the byte accepted in IDLE is header byte 0
  assign cur_pos_s  = (state_r == IDLE) ? 16'd0 : pos_r;
  assign in_hdr_s   = (state_r == IDLE) || (state_r == HDR);
  assign src_idx_s  = cur_pos_s[2:0] - 3'd6;
  assign len_full_s = {len_r[15:8], h2c_data};
  assign pay_end_s  = {1'b0, len_r} + {1'b0, HDR_LEN} - 17'd1;
  assign pay_exp_s  = pos_r[7:0] - HDR_LEN[7:0];
  assign fcs_idx_s  = pos_r[1:0] - len_r[1:0] - HDR_LEN[1:0];

`ifdef TRAFFIC_CHK_CRC_EN
  localparam logic SRC_CHK_EN = 1'b1;
  logic [31:0] crc_s;
  logic [31:0] fcs_word_s;

  traffic_crc32 u_crc (
    .user_clk    (user_clk),
    .user_resetn (user_resetn),
    .srst        (crc_srst_s),
    .en          (crc_en_s),
    .data        (h2c_data),
    .crc         (crc_s)
  );

  assign fcs_word_s = ~crc_s;
  assign fcs_exp_s  = fcs_word_s[{fcs_idx_s, 3'b000} +: 8];
`else
  localparam logic SRC_CHK_EN = 1'b0;
  logic unused_crc_s;
  assign unused_crc_s = crc_srst_s ^ crc_en_s;
  assign fcs_exp_s    = 8'h00;
`endif

  assign dst_bad_s = (cur_pos_s < 16'd6) && (h2c_data != mac_byte(DST_MAC, cur_pos_s[2:0]));
  assign src_bad_s = SRC_CHK_EN && (cur_pos_s >= 16'd6) && (cur_pos_s < 16'd12) &&
                     (h2c_data != mac_byte(SRC_MAC, src_idx_s));

  assign frame_err_s = fe_r | err_now_s;

  // Next state, per-byte checks and frame-end detection
  always_comb begin
    state_nx_s  = state_r;
    pos_nx_s    = pos_r;
    len_nx_s    = len_r;
    err_now_s   = 4'b0000;
    frame_end_s = 1'b0;
    crc_srst_s  = 1'b0;
    crc_en_s    = 1'b0;
    if (accept_s) begin
      pos_nx_s           = pos_r + 16'd1;
      err_now_s[ERR_DST] = in_hdr_s && (dst_bad_s || src_bad_s);
      case (state_r)
        IDLE: begin
          pos_nx_s           = 16'd1;
          crc_srst_s         = 1'b1;
          crc_en_s           = 1'b1;
          frame_end_s        = h2c_last;
          err_now_s[ERR_LEN] = h2c_last;
          state_nx_s         = h2c_last ? IDLE : HDR;
        end
        HDR: begin
          crc_en_s = 1'b1;
          if (pos_r == HDR_LEN - 16'd2) begin
            len_nx_s = {h2c_data, len_r[7:0]};
          end else if (pos_r == HDR_LEN - 16'd1) begin
            len_nx_s = len_full_s;
          end else begin
            len_nx_s = len_r;
          end
          if (h2c_last) begin
            frame_end_s        = 1'b1;
            err_now_s[ERR_LEN] = 1'b1;
            state_nx_s         = IDLE;
          end else if (pos_r == HDR_LEN - 16'd1) begin
            if (len_full_s == 16'd0) begin
              state_nx_s = FCS;
            end else if (len_full_s > MAX_ETH_FRAME) begin
              err_now_s[ERR_LEN] = 1'b1;
              state_nx_s         = DROP;
            end else begin
              state_nx_s = PAYLOAD;
            end
          end else begin
            state_nx_s = HDR;
          end
        end
        PAYLOAD: begin
          crc_en_s           = 1'b1;
          err_now_s[ERR_PAT] = (h2c_data != pay_exp_s);
          if (h2c_last) begin
            frame_end_s        = 1'b1;
            err_now_s[ERR_LEN] = 1'b1;
            state_nx_s         = IDLE;
          end else if ({1'b0, pos_r} == pay_end_s) begin
            state_nx_s = FCS;
          end else begin
            state_nx_s = PAYLOAD;
          end
        end
        FCS: begin
          err_now_s[ERR_FCS] = (h2c_data != fcs_exp_s);
          if (fcs_idx_s == FCS_LAST) begin
            // Missing last on the final FCS byte: frame is closed by the later last in DROP
            frame_end_s        = h2c_last;
            err_now_s[ERR_LEN] = !h2c_last;
            state_nx_s         = h2c_last ? IDLE : DROP;
          end else if (h2c_last) begin
            frame_end_s        = 1'b1;
            err_now_s[ERR_LEN] = 1'b1;
            state_nx_s         = IDLE;
          end else begin
            state_nx_s = FCS;
          end
        end
        DROP: begin
          frame_end_s = h2c_last;
          state_nx_s  = h2c_last ? IDLE : DROP;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Frame-tracking state, per-frame error accumulation and enable sampling
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      state_r <= IDLE;
      pos_r   <= 16'd0;
      len_r   <= 16'd0;
      fe_r    <= 4'b0000;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pos_r   <= pos_nx_s;
      len_r   <= len_nx_s;
      en_r    <= control_reg[1];
      busy_r  <= (state_nx_s != IDLE);
      if (frame_end_s) begin
        fe_r <= 4'b0000;
      end else if (accept_s) begin
        fe_r <= frame_err_s;
      end else begin
        fe_r <= fe_r;
      end
    end
  end

  // Statistics: clear has priority over any count in the same cycle
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      good_r  <= 32'd0;
      bad_r   <= 32'd0;
      rx_r    <= 32'd0;
      flags_r <= 4'b0000;
    end else if (clr_s) begin
      good_r  <= 32'd0;
      bad_r   <= 32'd0;
      rx_r    <= 32'd0;
      flags_r <= 4'b0000;
    end else begin
      rx_r <= accept_s ? sat_inc32(rx_r) : rx_r;
      if (frame_end_s) begin
        good_r  <= (|frame_err_s) ? good_r : sat_inc32(good_r);
        bad_r   <= (|frame_err_s) ? sat_inc32(bad_r) : bad_r;
        flags_r <= flags_r | frame_err_s;
      end else begin
        good_r  <= good_r;
        bad_r   <= bad_r;
        flags_r <= flags_r;
      end
    end
  end

  assign good_frames = good_r;
  assign bad_frames  = bad_r;
  assign rx_bytes    = rx_r;
  assign err_flags   = flags_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_traffic_chk.sv
// tb_traffic_chk: directed self-checking bench for traffic_chk; frames are built in a byte
// queue with hand-known header/payload contents and FCS (zeros, or CRC32 with TRAFFIC_CHK_CRC_EN).
module tb_traffic_chk;

  logic        user_clk = 1'b0;
  logic        user_resetn;
  logic [31:0] control_reg;
  logic        h2c_valid, h2c_ben, h2c_last;
  logic [7:0]  h2c_data;
  logic        h2c_ready;
  logic [31:0] good_frames, bad_frames, rx_bytes;
  logic [3:0]  err_flags;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] fq[$];

  traffic_chk dut (
    .user_clk    (user_clk),
    .user_resetn (user_resetn),
    .control_reg (control_reg),
    .h2c_valid   (h2c_valid),
    .h2c_ben     (h2c_ben),
    .h2c_data    (h2c_data),
    .h2c_last    (h2c_last),
    .h2c_ready   (h2c_ready),
    .good_frames (good_frames),
    .bad_frames  (bad_frames),
    .rx_bytes    (rx_bytes),
    .err_flags   (err_flags),
    .busy        (busy)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    h2c_valid = 1'b1;
    h2c_ben   = 1'b1;
    h2c_data  = d;
    h2c_last  = l;
    waited    = 0;
    while (!h2c_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chk("ready_timeout", {31'd0, h2c_ready}, 32'd1);
    tick();
    h2c_valid = 1'b0;
    h2c_last  = 1'b0;
  endtask

  // Frame: DST(first byte dst0) | SRC | len | payload i[7:0] (FF at bad_idx) | FCS
  task automatic build_frame(input int len, input int bad_idx, input logic [7:0] dst0);
    logic [15:0] len16;
    logic [31:0] crc;
    logic        fb;
    fq.delete();
    fq.push_back(dst0);
    repeat (5) fq.push_back(8'h00);
    fq.push_back(8'h80);
    repeat (4) fq.push_back(8'h00);
    fq.push_back(8'h01);
    len16 = 16'(len);
    fq.push_back(len16[15:8]);
    fq.push_back(len16[7:0]);
    for (int i = 0; i < len; i++) fq.push_back((i == bad_idx) ? 8'hFF : 8'(i));
    crc = 32'hFFFF_FFFF;
    foreach (fq[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ fq[k][b];
        crc = {1'b0, crc[31:1]};
        if (fb) crc = crc ^ 32'hEDB8_8320;
      end
    end
    crc = ~crc;
`ifdef TRAFFIC_CHK_CRC_EN
    fq.push_back(crc[7:0]);
    fq.push_back(crc[15:8]);
    fq.push_back(crc[23:16]);
    fq.push_back(crc[31:24]);
`else
    repeat (4) fq.push_back(8'h00);
`endif
  endtask

  task automatic send_queue(input int dis_at, input bit clr_last);
    for (int i = 0; i < fq.size(); i++) begin
      if (i == dis_at) control_reg = 32'h0;
      if (clr_last && i == fq.size() - 1) control_reg = 32'h3;
      send_byte(fq[i], i == fq.size() - 1);
    end
    if (clr_last) control_reg = 32'h2;
  endtask

  task automatic do_clear();
    control_reg = 32'h3;
    tick();
    control_reg = 32'h2;
  endtask

  task automatic chk_stats(input string tag, input int g, input int b, input int rx, input logic [3:0] f);
    chk({tag, "_good"}, good_frames, 32'(g));
    chk({tag, "_bad"}, bad_frames, 32'(b));
    chk({tag, "_rx"}, rx_bytes, 32'(rx));
    chk({tag, "_flags"}, {28'd0, err_flags}, {28'd0, f});
  endtask

  initial begin
    user_resetn = 1'b0;
    control_reg = 32'h0;
    h2c_valid   = 1'b0;
    h2c_ben     = 1'b0;
    h2c_data    = 8'h00;
    h2c_last    = 1'b0;
    repeat (3) tick();
    chk_stats("reset", 0, 0, 0, 4'b0000);
    chk("reset_ready", {31'd0, h2c_ready}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    user_resetn = 1'b1;
    control_reg = 32'h2;
    repeat (2) tick();
    chk("enable_ready", {31'd0, h2c_ready}, 32'd1);

    // Nominal length-4 frame, 22 bytes
    build_frame(4, -1, 8'h80);
    send_queue(-1, 1'b0);
    chk("nominal_busy_low", {31'd0, busy}, 32'd0);
    tick();
    chk_stats("nominal", 1, 0, 22, 4'b0000);

    // Length 0: header + FCS only
    do_clear();
    build_frame(0, -1, 8'h80);
    send_queue(-1, 1'b0);
    tick();
    chk_stats("len0", 1, 0, 18, 4'b0000);

    // Payload byte 2 corrupted
    do_clear();
    build_frame(4, 2, 8'h80);
    send_queue(-1, 1'b0);
    tick();
    chk_stats("pay_err", 0, 1, 22, 4'b0100);

    // DST byte 0 wrong
    do_clear();
    build_frame(4, -1, 8'h00);
    send_queue(-1, 1'b0);
    tick();
    chk_stats("dst_err", 0, 1, 22, 4'b0001);

    // Oversize length 1501 dropped until last (20 bytes sent)
    do_clear();
    build_frame(1501, -1, 8'h80);
    while (fq.size() > 20) void'(fq.pop_back());
    send_queue(-1, 1'b0);
    tick();
    chk_stats("oversize", 0, 1, 20, 4'b0010);

    // Early last on byte 10, then a good frame
    do_clear();
    build_frame(4, -1, 8'h80);
    while (fq.size() > 11) void'(fq.pop_back());
    send_queue(-1, 1'b0);
    chk("early_busy_low", {31'd0, busy}, 32'd0);
    tick();
    chk_stats("early", 0, 1, 11, 4'b0010);
    build_frame(4, -1, 8'h80);
    send_queue(-1, 1'b0);
    tick();
    chk_stats("after_early", 1, 1, 33, 4'b0010);

    // Enable dropped mid-frame: frame completes, ready falls afterwards
    do_clear();
    build_frame(4, -1, 8'h80);
    send_queue(5, 1'b0);
    chk("dis_ready_low", {31'd0, h2c_ready}, 32'd0);
    tick();
    chk_stats("dis_mid", 1, 0, 22, 4'b0000);

    // Valid held while disabled
    h2c_valid = 1'b1;
    h2c_ben   = 1'b1;
    h2c_data  = 8'hAA;
    h2c_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dis_hold_ready", {31'd0, h2c_ready}, 32'd0);
    end
    h2c_valid = 1'b0;
    h2c_last  = 1'b0;
    chk_stats("dis_hold", 1, 0, 22, 4'b0000);

    // Clear coinciding with a frame end
    control_reg = 32'h2;
    repeat (2) tick();
    build_frame(4, 2, 8'h80);
    send_queue(-1, 1'b1);
    tick();
    chk_stats("clr_end", 0, 0, 0, 4'b0000);

    // Reset mid-frame discards the partial frame
    build_frame(4, -1, 8'h80);
    for (int i = 0; i < 7; i++) send_byte(fq[i], 1'b0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    user_resetn = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, h2c_ready}, 32'd0);
    chk("rst_rx", rx_bytes, 32'd0);
    tick();
    user_resetn = 1'b1;
    repeat (2) tick();
    send_queue(-1, 1'b0);
    tick();
    chk_stats("post_rst", 1, 0, 22, 4'b0000);

`ifdef TRAFFIC_CHK_CRC_EN
    do_clear();
    build_frame(6, -1, 8'h80);
    send_queue(-1, 1'b0);
    tick();
    chk_stats("crc_good", 1, 0, 24, 4'b0000);
    do_clear();
    build_frame(6, -1, 8'h80);
    fq[fq.size() - 2] = fq[fq.size() - 2] ^ 8'h10;
    send_queue(-1, 1'b0);
    tick();
    chk_stats("crc_bad", 0, 1, 24, 4'b1000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
